// File: rtl/finger_pkg.sv
// Shared state encoding and default constants for the round judge block.
// Latency: none (types and constants only).
// Backpressure: none.
package finger_pkg;
    localparam int LIVES_W       = 2;
    localparam int KEYS_DEF      = 4;
    localparam int DB_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_OPEN = 3'd1,
        ARMED     = 3'd2,
        DONE      = 3'd3,
        OVER      = 3'd4
    } judgeState_t;
endpackage

// File: rtl/key_edge.sv
// Synchronizes and debounces raw push buttons, emitting a one-cycle press pulse per debounced rise.
// Latency: raw rise to press pulse is DB_CYCLES+3 cycles.
// Backpressure: none; presses are pulses and are dropped if nobody looks.
module key_edge #(
    parameter int KEYS      = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [KEYS-1:0] keys,
    output logic [KEYS-1:0] press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [KEYS-1:0]         sync1;
    logic [KEYS-1:0]         sync2;
    logic [KEYS-1:0]         level;
    logic [KEYS-1:0]         levelQ;
    logic [KEYS-1:0][CW-1:0] stableCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            level     <= '0;
            levelQ    <= '0;
            press     <= '0;
            stableCnt <= '0;
        end else begin
            sync1  <= keys;
            sync2  <= sync1;
            levelQ <= level;
            press  <= level & ~levelQ;
            // Level only follows the synchronized key after DB_CYCLES consecutive disagreeing samples.
            for (int i = 0; i < KEYS; i++) begin
                if (sync2[i] == level[i]) begin
                    stableCnt[i] <= '0;
                end else if (stableCnt[i] == CNT_LAST) begin
                    level[i]     <= sync2[i];
                    stableCnt[i] <= '0;
                end else begin
                    stableCnt[i] <= stableCnt[i] + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/round_judge.sv
// Judges debounced key presses against the latched target in each round window; keeps score and lives.
// Latency: hit/miss registered one cycle after the deciding press or window fall.
// Backpressure: none; one verdict per window, extra presses are ignored.
module round_judge
    import finger_pkg::*;
#(
    parameter int KEYS      = KEYS_DEF,
    parameter int SCORE_W   = 8,
    parameter int LIVES     = 3,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gameState,
    input  logic               window,
    input  logic [KEYS-1:0]    target,
    input  logic [KEYS-1:0]    keys,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               gameOver
);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    judgeState_t        state;
    judgeState_t        stateNext;
    logic               windowQ;
    logic [KEYS-1:0]    targetQ;
    logic [KEYS-1:0]    targetNext;
    logic [KEYS-1:0]    press;
    logic               hitNext;
    logic               missNext;
    logic [SCORE_W-1:0] scoreNext;
    logic [LIVES_W-1:0] livesNext;
    logic [LIVES_W-1:0] livesDec;
    logic               rise;
    logic               fall;

    key_edge #(
        .KEYS      (KEYS),
        .DB_CYCLES (DB_CYCLES)
    ) keyEdge (
        .clk   (clk),
        .rst   (rst),
        .keys  (keys),
        .press (press)
    );

    assign rise     = window & ~windowQ;
    assign fall     = ~window & windowQ;
    assign livesDec = lives - 1'b1;
    assign gameOver = (state == OVER);

    always_comb begin
        stateNext  = state;
        targetNext = targetQ;
        hitNext    = 1'b0;
        missNext   = 1'b0;
        scoreNext  = score;
        livesNext  = lives;
        if (!gameState) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    stateNext = WAIT_OPEN;
                    scoreNext = '0;
                    livesNext = LIVES_INIT;
                end
                WAIT_OPEN: begin
                    if (rise) begin
                        targetNext = target;
                        stateNext  = ARMED;
                    end
                end
                ARMED: begin
                    // A press in the fall cycle wins over the timeout.
                    if (press != '0 && press == targetQ) begin
                        hitNext   = 1'b1;
                        scoreNext = (&score) ? score : score + 1'b1;
                        stateNext = DONE;
                    end else if (press != '0 || fall) begin
                        missNext  = 1'b1;
                        livesNext = livesDec;
                        if (livesDec == '0) begin
                            stateNext = OVER;
                        end else if (window) begin
                            stateNext = DONE;
                        end else begin
                            stateNext = WAIT_OPEN;
                        end
                    end
                end
                DONE: begin
                    if (fall) begin
                        stateNext = WAIT_OPEN;
                    end
                end
                OVER: begin
                    stateNext = OVER;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            windowQ <= 1'b0;
            targetQ <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
            lives   <= LIVES_INIT;
        end else begin
            state   <= stateNext;
            windowQ <= window;
            targetQ <= targetNext;
            hit     <= hitNext;
            miss    <= missNext;
            score   <= scoreNext;
            lives   <= livesNext;
        end
    end
endmodule

// File: tb/tb_round_judge.sv
// Randomized and directed bench for round_judge, scored against a behavioural game model.
module tb_round_judge;
    localparam int KEYS_T    = 4;
    localparam int SCORE_W_T = 2;
    localparam int LIVES_T   = 3;
    localparam int DB_T      = 4;
    localparam int SCORE_MAX = (1 << SCORE_W_T) - 1;
    localparam int HIST      = DB_T + 2;
    localparam int M_IDLE = 0, M_WAIT = 1, M_ARMED = 2, M_DONE = 3, M_OVER = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 gameState = 1'b0;
    logic                 window = 1'b0;
    logic [KEYS_T-1:0]    target = '0;
    logic [KEYS_T-1:0]    keys = '0;
    logic                 hit;
    logic                 miss;
    logic [SCORE_W_T-1:0] score;
    logic [1:0]           lives;
    logic                 gameOver;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int                mSt = M_IDLE;
    int                scoreM = 0;
    int                livesM = LIVES_T;
    logic              hitM = 1'b0;
    logic              missM = 1'b0;
    logic              winQM = 1'b0;
    logic [KEYS_T-1:0] tgtM = '0;
    logic [KEYS_T-1:0] pressM = '0;
    logic [KEYS_T-1:0] dbM = '0;
    logic [KEYS_T-1:0] dbPrevM = '0;
    logic [KEYS_T-1:0] rawHist [0:HIST-1];

    round_judge #(
        .KEYS      (KEYS_T),
        .SCORE_W   (SCORE_W_T),
        .LIVES     (LIVES_T),
        .DB_CYCLES (DB_T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gameState (gameState),
        .window    (window),
        .target    (target),
        .keys      (keys),
        .hit       (hit),
        .miss      (miss),
        .score     (score),
        .lives     (lives),
        .gameOver  (gameOver)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic modelMiss();
        missM = 1'b1;
        livesM--;
        if (livesM == 0)  mSt = M_OVER;
        else if (window)  mSt = M_DONE;
        else              mSt = M_WAIT;
    endtask

    // One clock edge of the game: judge with the press visible before the edge, then advance the key front end.
    task automatic modelStep();
        logic              rise;
        logic              fall;
        logic              flip;
        logic [KEYS_T-1:0] pressNew;
        if (rst) begin
            mSt = M_IDLE; scoreM = 0; livesM = LIVES_T; hitM = 0; missM = 0;
            winQM = 0; tgtM = '0; pressM = '0; dbM = '0; dbPrevM = '0;
            for (int i = 0; i < HIST; i++) rawHist[i] = '0;
        end else begin
            rise = window && !winQM;
            fall = !window && winQM;
            hitM = 0;
            missM = 0;
            if (!gameState) begin
                mSt = M_IDLE;
            end else begin
                case (mSt)
                    M_IDLE: begin mSt = M_WAIT; scoreM = 0; livesM = LIVES_T; end
                    M_WAIT: if (rise) begin tgtM = target; mSt = M_ARMED; end
                    M_ARMED: begin
                        if (pressM != 0 && pressM == tgtM) begin
                            hitM = 1'b1;
                            if (scoreM < SCORE_MAX) scoreM++;
                            mSt = M_DONE;
                        end else if (pressM != 0 || fall) begin
                            modelMiss();
                        end
                    end
                    M_DONE: if (fall) mSt = M_WAIT;
                    default: ;
                endcase
            end
            winQM = window;
            for (int i = HIST - 1; i > 0; i--) rawHist[i] = rawHist[i-1];
            rawHist[0] = keys;
            pressNew = dbM & ~dbPrevM;
            dbPrevM = dbM;
            // debounced level flips once the last DB_T synchronized samples all disagree with it
            for (int b = 0; b < KEYS_T; b++) begin
                flip = 1'b1;
                for (int h = 2; h < HIST; h++)
                    if (rawHist[h][b] == dbM[b]) flip = 1'b0;
                if (flip) dbM[b] = ~dbM[b];
            end
            pressM = pressNew;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        check("hit", 32'(hit), 32'(hitM));
        check("miss", 32'(miss), 32'(missM));
        check("score", 32'(score), scoreM);
        check("lives", 32'(lives), livesM);
        check("gameOver", 32'(gameOver), (mSt == M_OVER) ? 1 : 0);
        check("hit_miss_excl", 32'(hit & miss), 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic openWindow(input logic [KEYS_T-1:0] tg);
        target = tg;
        window = 1'b1;
        tick();
    endtask

    task automatic waitVerdict(output int n, output int gotHit, output int gotMiss);
        n = 0; gotHit = 0; gotMiss = 0;
        while (n < 40 && gotHit == 0 && gotMiss == 0) begin
            tick();
            n++;
            gotHit  = 32'(hit);
            gotMiss = 32'(miss);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, gh, gm, pulses;
        int r, len, gap, act, hold, off;
        logic [KEYS_T-1:0] tg, kv;

        rst = 1'b1;
        cyc(2);
        check("rst_hit", 32'(hit), 0);
        check("rst_miss", 32'(miss), 0);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), 3);
        check("rst_gameOver", 32'(gameOver), 0);
        rst = 1'b0;
        gameState = 1'b1;
        cyc(2);

        // correct press: hit eight cycles after the raw key goes high
        openWindow(4'b0100);
        keys = 4'b0100;
        waitVerdict(n, gh, gm);
        check("correct_latency", n, 8);
        check("correct_hit", gh, 1);
        check("correct_score", 32'(score), 1);
        check("correct_lives", 32'(lives), 3);
        keys = '0; cyc(2); window = 1'b0; cyc(10);

        // wrong key
        openWindow(4'b0001);
        keys = 4'b0010;
        waitVerdict(n, gh, gm);
        check("wrong_miss", gm, 1);
        check("wrong_lives", 32'(lives), 2);
        keys = '0; cyc(2); window = 1'b0; cyc(10);

        // timeout
        openWindow(4'b0010);
        cyc(8); window = 1'b0; tick();
        check("timeout_miss", 32'(miss), 1);
        check("timeout_lives", 32'(lives), 1);
        cyc(4);

        // game over, then silence until stop
        openWindow(4'b0010);
        cyc(5); window = 1'b0; tick();
        check("over_miss", 32'(miss), 1);
        check("over_lives", 32'(lives), 0);
        check("over_flag", 32'(gameOver), 1);
        cyc(3);
        pulses = 0;
        openWindow(4'b0001);
        keys = 4'b0001;
        repeat (12) begin tick(); pulses += 32'(hit | miss); end
        keys = '0; window = 1'b0;
        repeat (3) begin tick(); pulses += 32'(hit | miss); end
        check("over_quiet", pulses, 0);
        gameState = 1'b0; tick();
        check("stop_clears_over", 32'(gameOver), 0);
        gameState = 1'b1; tick();
        check("restart_score", 32'(score), 0);
        check("restart_lives", 32'(lives), 3);
        cyc(10);

        // press in the same cycle as the window fall
        openWindow(4'b1000);
        keys = 4'b1000;
        cyc(7); window = 1'b0; tick();
        check("press_at_fall_hit", 32'(hit), 1);
        check("press_at_fall_miss", 32'(miss), 0);
        keys = '0;
        openWindow(4'b0001); cyc(3); window = 1'b0; cyc(10);

        // two keys at once, then a second press in DONE
        openWindow(4'b0001);
        keys = 4'b0011;
        waitVerdict(n, gh, gm);
        check("two_keys_miss", gm, 1);
        keys = '0; cyc(8);
        keys = 4'b0001;
        pulses = 0;
        repeat (12) begin tick(); pulses += 32'(hit | miss); end
        check("done_ignores", pulses, 0);
        keys = '0; window = 1'b0; cyc(10);

        // score saturation
        repeat (5) begin
            openWindow(4'b0100);
            keys = 4'b0100;
            waitVerdict(n, gh, gm);
            check("sat_hit", gh, 1);
            keys = '0; cyc(2); window = 1'b0; cyc(10);
        end
        check("sat_score", 32'(score), 3);

        // short glitch gives no press; timeout follows
        openWindow(4'b0010);
        keys = 4'b0010; cyc(3); keys = '0; cyc(10);
        window = 1'b0; tick();
        check("glitch_timeout", 32'(miss), 1);
        check("glitch_lives", 32'(lives), 1);
        cyc(3);

        // reset with a press pending in ARMED
        openWindow(4'b0100);
        keys = 4'b0100; cyc(7);
        rst = 1'b1; tick();
        check("mid_rst_hit", 32'(hit), 0);
        check("mid_rst_score", 32'(score), 0);
        check("mid_rst_lives", 32'(lives), 3);
        check("mid_rst_gameOver", 32'(gameOver), 0);
        rst = 1'b0; keys = '0; window = 1'b0; cyc(10);

        // stop with a press pending in ARMED
        openWindow(4'b0100);
        keys = 4'b0100; cyc(7);
        gameState = 1'b0; tick();
        check("stop_hit", 32'(hit), 0);
        check("stop_miss", 32'(miss), 0);
        gameState = 1'b1; keys = '0; window = 1'b0; cyc(10);

        // randomized windows
        for (int w = 0; w < 50; w++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else if (r < 12 || gameOver) begin
                gameState = 1'b0; cyc($urandom_range(1, 3)); gameState = 1'b1;
            end
            len = $urandom_range(3, 24);
            gap = $urandom_range(2, 12);
            tg  = 4'b0001 << $urandom_range(0, 3);
            act = $urandom_range(0, 3);
            case (act)
                0:       kv = '0;
                2:       kv = 4'($urandom_range(1, 15));
                default: kv = tg;
            endcase
            hold = (act == 3) ? $urandom_range(1, 3) : $urandom_range(4, 12);
            off  = $urandom_range(0, len);
            target = tg;
            for (int c = 0; c < len + gap; c++) begin
                window = (c < len);
                keys   = (c >= off && c < off + hold) ? kv : '0;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_judge.md
# round_judge

Consumer of the round-window signal produced by the round timer: judges the player's key press against the expected key during each active window and keeps score and lives. It sits between the round timer output, the debounced-by-this-block push buttons and the display/score logic. It emits one hit-or-miss verdict per window and raises game-over when lives run out.

## Interface
- `KEYS`, 4: number of player keys; `target` and `keys` width.
- `SCORE_W`, 8: score counter width.
- `LIVES`, 3: lives loaded at game start (1..3).
- `DB_CYCLES`, 16: cycles a raw key must be stable before it is accepted (≥1).

- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `gameState`  in  1  1 = game running, 0 = stopped.
- `window`  in  1  round-active level from the round timer; high = press expected.
- `target`  in  KEYS  one-hot expected key; sampled on window rise.
- `keys`  in  KEYS  raw asynchronous push buttons, active-high.
- `hit`  out  1  one-cycle pulse: correct key pressed in window.
- `miss`  out  1  one-cycle pulse: wrong key, or no press before the window closed.
- `score`  out  SCORE_W  hits this game; saturates at all-ones.
- `lives`  out  2  remaining lives.
- `gameOver`  out  1  level; high while lives = 0 and `gameState` = 1.

## Operation
- Reset values: `hit`=0, `miss`=0, `score`=0, `lives`=LIVES, `gameOver`=0, state IDLE, `window_q`=0, target latch=0.
- `window_q` registers `window` every cycle. rise = `window` & ~`window_q`. fall = ~`window` & `window_q`.
- `press` is the KEYS-wide one-cycle rising-edge vector of the debounced keys from `key_edge`.
- IDLE: outputs held. When `gameState`=1, go to WAIT_OPEN, clear `score` and reload `lives`=LIVES.
- WAIT_OPEN: `press` is ignored. On rise, latch `target` and go to ARMED.
- ARMED:
  - `press`≠0 and `press` equals the latched target: pulse `hit`, increment `score` (saturating), go to DONE.
  - `press`≠0 and any mismatch, including several keys in one cycle: pulse `miss` and decrement `lives`.
  - fall with `press`=0: pulse `miss` and decrement `lives`.
  - After a miss, go to OVER if the new `lives`=0; otherwise go to DONE if `window` is still high, or to WAIT_OPEN if it is low.
  - A press and a fall in the same cycle: the press is judged and the fall is ignored.
- DONE: further presses are ignored. On fall, go to WAIT_OPEN.
- OVER: `gameOver`=1 and all presses are ignored. When `gameState`=0, go to IDLE; `gameOver` clears there.
- `gameState`=0 in any state forces IDLE on the next cycle with no pulse. `score` and `lives` hold their values until the next start.
- `rst` mid-round: all registers return to their reset values on the next edge, and any pending verdict is dropped.
- `hit` and `miss` are never high together; at most one verdict is given per window.

## Timing
- `key_edge` path: 2-flop synchronizer, then a stability counter. The debounced level changes after the synchronized value has been stable for DB_CYCLES cycles. A rising edge of the debounced level gives a `press` pulse.
- Raw key going high at edge t and held stable: `press` pulse at edge t+DB_CYCLES+3.
- `hit`/`miss` are registered and are high during the cycle after the deciding `press` or fall. `score` and `lives` update on the same edge.
- A `press` in the same cycle as rise is ignored; ARMED is effective from the cycle after rise.
- `gameOver` rises on the same edge as the final `miss`.
- A key released and re-pressed within DB_CYCLES produces no new `press`.

## Structure
- Package `finger_pkg`:
  - state enum IDLE/WAIT_OPEN/ARMED/DONE/OVER, 3-bit encoding;
  - `LIVES_W`=2;
  - default constants for `KEYS` and `DB_CYCLES`.
- Sub-module `key_edge`, parameterized on `KEYS` and `DB_CYCLES`: synchronizer, per-key debounce counter and rise detect. It is instantiated once in `round_judge`.
- `round_judge` contains the FSM, the target latch, the window edge detect and the score/lives counters.

## Test plan
All scenarios use DB_CYCLES=4, LIVES=3.

- Correct press: `gameState`=1, window rise with `target`=4'b0100, raw `keys`=4'b0100 from edge t → `hit` pulse at t+8, `score`=1, `lives`=3.
- Wrong key, then timeout: `target`=4'b0001 and press 4'b0010 → `miss`, `lives`=2. Next window with no press → `miss` at fall+1, `lives`=1.
- Game over: third miss → `lives`=0 and `gameOver`=1 on the same edge. Further windows and presses give no pulses. `gameState`=0 → IDLE; restart gives `score`=0, `lives`=3.
- Simultaneous events and one verdict per window:
  - correct `press` in the same cycle as fall → `hit`, not `miss`;
  - two keys 4'b0011 pressed together → `miss`;
  - a second press in DONE → no pulse.
- Saturation and bounce: SCORE_W=2 with 5 hits → `score` stays 3. A raw key glitch shorter than 4 cycles → no `press`, and a timeout `miss` follows.
- Reset and stop mid-round: `rst` asserted in ARMED → next cycle all outputs at reset values. `gameState` dropped in ARMED → IDLE with no `hit`/`miss`.
